// File: rtl/hazard_pkg.sv
// Shared types and constants for the second-generation hazard controller.
package hazard_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    SQUASH = 1'b1
  } fetch_state_t;

  localparam int PERF_IMEM       = 0;
  localparam int PERF_DMEM       = 1;
  localparam int PERF_LOAD_USE   = 2;
  localparam int PERF_MISPREDICT = 3;
  localparam int PERF_MDU        = 4;
  localparam int NUM_PERF        = 5;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Bank of saturating stall-cause counters; a clear beats any same-cycle increment.
module hazard_perf_cnt
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [NUM_PERF-1:0]       inc,
  output logic [NUM_PERF*CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q [NUM_PERF];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PERF; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_PERF; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PERF; i++) begin
        if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + ONE;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_PERF; i++) cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Pipeline hazard controller for the 5-stage rv32i core: stalls, load-use
// bubbles, redirect flushes, stale-fetch squashing and stall-cause counters.
module hazard_ctrl_gen2
  import hazard_pkg::*;
#(
  parameter int REG_W            = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MDU_EN           = 1,
  parameter int CNT_W            = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_resp,
  input  logic                      dmem_req,
  input  logic                      dmem_resp,
  input  logic [REG_W-1:0]          rs1_id,
  input  logic [REG_W-1:0]          rs2_id,
  input  logic                      rs1_used_id,
  input  logic                      rs2_used_id,
  input  logic                      ex_is_load,
  input  logic [REG_W-1:0]          rd_ex,
  input  logic                      mispredict_ex,
  input  logic                      mdu_busy,
  input  logic                      perf_clr,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      idex_en,
  output logic                      exmem_en,
  output logic                      memwb_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      predict_en,
  output logic                      fetch_squash,
  output logic [NUM_PERF*CNT_W-1:0] perf_cnt
);

  localparam logic [1:0] BUB_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  fetch_state_t      state;
  logic [1:0]        bub_cnt;
  logic              mem_ok, ex_ok, back_adv, fetch_ok;
  logic              lu_hit, lu_active;
  logic [NUM_PERF-1:0] perf_inc;

  assign mem_ok    = ~dmem_req | dmem_resp;
  assign ex_ok     = ~((MDU_EN != 0) & mdu_busy);
  assign back_adv  = mem_ok & ex_ok;
  assign fetch_ok  = imem_resp & (state == FETCH);
  assign lu_hit    = ex_is_load & (rd_ex != '0) &
                     ((rs1_used_id & (rd_ex == rs1_id)) | (rs2_used_id & (rd_ex == rs2_id)));
  assign lu_active = back_adv & (lu_hit | (bub_cnt != 2'd0));

  // Redirect outranks load-use, which outranks normal fetch.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst && back_adv) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (mispredict_ex) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_active) begin
        idex_flush = 1'b1;
      end else begin
        ifid_en    = 1'b1;
        pc_en      = fetch_ok;
        ifid_flush = ~fetch_ok;
      end
    end
  end

  assign predict_en   = ifid_en | idex_en;
  assign fetch_squash = (state == SQUASH);

  // A redirect seen while already squashing keeps discarding responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      bub_cnt <= 2'd0;
    end else begin
      if (back_adv) begin
        if (mispredict_ex)
          bub_cnt <= 2'd0;
        else if (lu_active)
          bub_cnt <= (lu_hit && (bub_cnt == 2'd0)) ? BUB_RELOAD : bub_cnt - 2'd1;
      end
      case (state)
        FETCH:  if (back_adv && mispredict_ex && !imem_resp) state <= SQUASH;
        SQUASH: if (imem_resp && !(back_adv && mispredict_ex)) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    perf_inc                  = '0;
    perf_inc[PERF_IMEM]       = back_adv & ~fetch_ok & ~mispredict_ex & ~lu_active;
    perf_inc[PERF_DMEM]       = ~mem_ok;
    perf_inc[PERF_LOAD_USE]   = lu_active & ~mispredict_ex;
    perf_inc[PERF_MISPREDICT] = back_adv & mispredict_ex;
    perf_inc[PERF_MDU]        = mem_ok & ~ex_ok;
  end

  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk(clk),
    .rst(rst),
    .clr(perf_clr),
    .inc(perf_inc),
    .cnt(perf_cnt)
  );

endmodule
